// File: rtl/dest_sched_pkg.sv
// Shared types, constants and pointer helpers for the destination write scheduler.
package dest_sched_pkg;

  localparam int unsigned PTR_W = 3;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sched_state_t;

  localparam logic [PTR_W-1:0] PTR_RST = 3'b100;

  localparam logic REQ_ID_A = 1'b0;
  localparam logic REQ_ID_B = 1'b1;

  // Register index to one-hot pointer; index 3 has no register and maps to zero.
  function automatic logic [PTR_W-1:0] idxToOneHot(input logic [IDX_W-1:0] idx);
    logic [PTR_W-1:0] oneHot;
    oneHot = '0;
    case (idx)
      2'd0:    oneHot = 3'b001;
      2'd1:    oneHot = 3'b010;
      2'd2:    oneHot = 3'b100;
      default: oneHot = '0;
    endcase
    return oneHot;
  endfunction

  // Pointer rotation R2 -> R0 -> R1 -> R2.
  function automatic logic [PTR_W-1:0] rotatePtr(input logic [PTR_W-1:0] ptr);
    return {ptr[PTR_W-2:0], ptr[PTR_W-1]};
  endfunction

endpackage

// File: rtl/dest_ptr_ring.sv
// One-hot rotating destination pointer with a priority load.
module dest_ptr_ring
  import dest_sched_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                ADV,
  input  logic                LD,
  input  logic [IDX_W-1:0]    LD_VAL,
  output logic [PTR_W-1:0]    PTR
);

  // Load wins over advance; a load of index 3 leaves the pointer untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PTR <= PTR_RST;
    end else if (LD) begin
      if (LD_VAL != 2'd3) begin
        PTR <= idxToOneHot(LD_VAL);
      end
    end else if (ADV) begin
      PTR <= rotatePtr(PTR);
    end
  end

endmodule

// File: rtl/dest_write_sched.sv
// Arbitrates ALU and bus-load writers into the three destination registers.
// Each grant produces a one-cycle one-hot write strobe, then the pointer rotates.
// Only NREG = 3 is supported.
module dest_write_sched
  import dest_sched_pkg::*;
#(
  parameter int unsigned DW   = 4,
  parameter int unsigned NREG = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic [DW-1:0]     DATA_A,
  output logic              ACK_A,
  input  logic              REQ_B,
  input  logic [DW-1:0]     DATA_B,
  output logic              ACK_B,
  input  logic              HOLD,
  input  logic              PTR_LD,
  input  logic [IDX_W-1:0]  PTR_VAL,
  output logic [NREG-1:0]   WE,
  output logic [DW-1:0]     WDATA,
  output logic [NREG-1:0]   PTR,
  output logic              BUSY
);

  sched_state_t      state;
  sched_state_t      stateD;
  logic              lastGrant;
  logic              lastGrantD;
  logic [NREG-1:0]   weD;
  logic [DW-1:0]     wdataD;
  logic              ackAD;
  logic              ackBD;
  logic              pickA;
  logic              ptrAdv;
  logic              ptrLd;
  logic [PTR_W-1:0]  ringPtr;

  dest_ptr_ring uPtrRing (
    .CLK    (CLK),
    .RST    (RST),
    .ADV    (ptrAdv),
    .LD     (ptrLd),
    .LD_VAL (PTR_VAL),
    .PTR    (ringPtr)
  );

  assign PTR  = NREG'(ringPtr);
  assign BUSY = (state == WRITE);

  // State, round-robin flag and registered write/ack outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lastGrant <= REQ_ID_B;
      WE        <= '0;
      WDATA     <= '0;
      ACK_A     <= 1'b0;
      ACK_B     <= 1'b0;
    end else begin
      state     <= stateD;
      lastGrant <= lastGrantD;
      WE        <= weD;
      WDATA     <= wdataD;
      ACK_A     <= ackAD;
      ACK_B     <= ackBD;
    end
  end

  // Next-state, arbitration and pointer control; pointer load beats a grant in IDLE.
  always_comb begin
    stateD     = state;
    lastGrantD = lastGrant;
    weD        = '0;
    wdataD     = WDATA;
    ackAD      = 1'b0;
    ackBD      = 1'b0;
    ptrAdv     = 1'b0;
    ptrLd      = 1'b0;
    pickA      = REQ_A && (!REQ_B || (lastGrant == REQ_ID_B));

    case (state)
      IDLE: begin
        if (PTR_LD) begin
          ptrLd = 1'b1;
        end else if (!HOLD && (REQ_A || REQ_B)) begin
          stateD = WRITE;
          weD    = PTR;
          if (pickA) begin
            wdataD     = DATA_A;
            ackAD      = 1'b1;
            lastGrantD = REQ_ID_A;
          end else begin
            wdataD     = DATA_B;
            ackBD      = 1'b1;
            lastGrantD = REQ_ID_B;
          end
        end
      end
      WRITE: begin
        stateD = IDLE;
        ptrAdv = 1'b1;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dest_write_sched.sv
// Self-checking bench for dest_write_sched: directed scenarios plus a randomized
// run against an index-based reference model.
module tb_dest_write_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_A;
  logic [3:0] DATA_A;
  logic       ACK_A;
  logic       REQ_B;
  logic [3:0] DATA_B;
  logic       ACK_B;
  logic       HOLD;
  logic       PTR_LD;
  logic [1:0] PTR_VAL;
  logic [2:0] WE;
  logic [3:0] WDATA;
  logic [2:0] PTR;
  logic       BUSY;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: pointer kept as a register index, busy flag, last winner.
  int       mIdx;
  bit       mBusy;
  bit       mLastA;
  bit [2:0] mWe;
  bit [3:0] mWdata;
  bit       mAckA;
  bit       mAckB;

  dest_write_sched #(.DW(4), .NREG(3)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ_A  (REQ_A),
    .DATA_A (DATA_A),
    .ACK_A  (ACK_A),
    .REQ_B  (REQ_B),
    .DATA_B (DATA_B),
    .ACK_B  (ACK_B),
    .HOLD   (HOLD),
    .PTR_LD (PTR_LD),
    .PTR_VAL(PTR_VAL),
    .WE     (WE),
    .WDATA  (WDATA),
    .PTR    (PTR),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    RST = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; DATA_A = 4'h0; DATA_B = 4'h0;
    HOLD = 1'b0; PTR_LD = 1'b0; PTR_VAL = 2'd0;
  endtask

  task automatic doReset();
    clearInputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  function automatic bit [2:0] idxHot(input int idx);
    return 3'(1 << idx);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    if (RST) begin
      mBusy = 0; mIdx = 2; mWe = 0; mWdata = 0; mAckA = 0; mAckB = 0; mLastA = 0;
    end else if (mBusy) begin
      mBusy = 0; mWe = 0; mAckA = 0; mAckB = 0; mIdx = (mIdx + 1) % 3;
    end else begin
      mWe = 0; mAckA = 0; mAckB = 0;
      if (PTR_LD) begin
        if (PTR_VAL != 2'd3) mIdx = int'(PTR_VAL);
      end else if (!HOLD && (REQ_A || REQ_B)) begin
        mBusy = 1;
        mWe   = idxHot(mIdx);
        if (REQ_A && (!REQ_B || !mLastA)) begin
          mAckA = 1; mWdata = DATA_A; mLastA = 1;
        end else begin
          mAckB = 1; mWdata = DATA_B; mLastA = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 3; i++) begin
      nTests++;
      if ({PTR, WE, ACK_A, ACK_B, BUSY} !== {3'b100, 3'b000, 1'b0, 1'b0, 1'b0}) begin
        nFail++;
        $display("FAIL reset_idle cyc%0d: PTR=%b WE=%b ACK_A=%b ACK_B=%b BUSY=%b, want 100 000 0 0 0",
                 i, PTR, WE, ACK_A, ACK_B, BUSY);
      end
      tick();
    end
  endtask

  task automatic test_a_stream();
    logic [3:0] dat [3];
    logic [2:0] wes [3];
    dat[0] = 4'd5; dat[1] = 4'd9; dat[2] = 4'd3;
    wes[0] = 3'b100; wes[1] = 3'b001; wes[2] = 3'b010;
    doReset();
    REQ_A = 1'b1;
    for (int g = 0; g < 3; g++) begin
      DATA_A = dat[g];
      tick();
      nTests++;
      if ({ACK_A, ACK_B, WE, WDATA, BUSY} !== {1'b1, 1'b0, wes[g], dat[g], 1'b1}) begin
        nFail++;
        $display("FAIL a_stream_grant%0d: ACK_A=%b ACK_B=%b WE=%b WDATA=%h BUSY=%b, want 1 0 %b %h 1",
                 g, ACK_A, ACK_B, WE, WDATA, BUSY, wes[g], dat[g]);
      end
      if (g == 2) REQ_A = 1'b0;
      tick();
      nTests++;
      if ({ACK_A, WE, WDATA} !== {1'b0, 3'b000, dat[g]}) begin
        nFail++;
        $display("FAIL a_stream_gap%0d: ACK_A=%b WE=%b WDATA=%h, want 0 000 %h",
                 g, ACK_A, WE, WDATA, dat[g]);
      end
    end
    nTests++;
    if (PTR !== 3'b100) begin
      nFail++;
      $display("FAIL a_stream_ptr_end: PTR=%b want 100", PTR);
    end
  endtask

  task automatic test_tie();
    logic [2:0] wes [4];
    wes[0] = 3'b100; wes[1] = 3'b001; wes[2] = 3'b010; wes[3] = 3'b100;
    doReset();
    REQ_A = 1'b1; REQ_B = 1'b1; DATA_A = 4'hA; DATA_B = 4'hB;
    for (int g = 0; g < 4; g++) begin
      tick();
      nTests++;
      if ({ACK_A, ACK_B, WE, WDATA} !== {(g % 2 == 0), (g % 2 == 1), wes[g], (g % 2 == 0) ? 4'hA : 4'hB}) begin
        nFail++;
        $display("FAIL tie_grant%0d: ACK_A=%b ACK_B=%b WE=%b WDATA=%h, want %b %b %b %h",
                 g, ACK_A, ACK_B, WE, WDATA, (g % 2 == 0), (g % 2 == 1), wes[g],
                 (g % 2 == 0) ? 4'hA : 4'hB);
      end
      tick();
      nTests++;
      if ({ACK_A, ACK_B, WE} !== 5'b0) begin
        nFail++;
        $display("FAIL tie_gap%0d: ACK_A=%b ACK_B=%b WE=%b, want 0 0 000", g, ACK_A, ACK_B, WE);
      end
    end
    clearInputs();
  endtask

  task automatic test_hold();
    doReset();
    HOLD = 1'b1; REQ_B = 1'b1; DATA_B = 4'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++;
      if ({ACK_A, ACK_B, WE, BUSY} !== 6'b0) begin
        nFail++;
        $display("FAIL hold_block%0d: ACK_A=%b ACK_B=%b WE=%b BUSY=%b, want 0 0 000 0",
                 i, ACK_A, ACK_B, WE, BUSY);
      end
    end
    HOLD = 1'b0;
    tick();
    nTests++;
    if ({ACK_B, WE, WDATA} !== {1'b1, 3'b100, 4'h6}) begin
      nFail++;
      $display("FAIL hold_release: ACK_B=%b WE=%b WDATA=%h, want 1 100 6", ACK_B, WE, WDATA);
    end
    REQ_B = 1'b0;
    tick();
  endtask

  task automatic test_ptr_ld();
    // Pointer is at 001 after the hold scenario.
    PTR_LD = 1'b1; PTR_VAL = 2'd1; REQ_A = 1'b1; DATA_A = 4'h7;
    tick();
    nTests++;
    if ({PTR, ACK_A, BUSY} !== {3'b010, 1'b0, 1'b0}) begin
      nFail++;
      $display("FAIL ptr_ld_load: PTR=%b ACK_A=%b BUSY=%b, want 010 0 0", PTR, ACK_A, BUSY);
    end
    PTR_LD = 1'b0;
    tick();
    nTests++;
    if ({ACK_A, WE, WDATA} !== {1'b1, 3'b010, 4'h7}) begin
      nFail++;
      $display("FAIL ptr_ld_grant: ACK_A=%b WE=%b WDATA=%h, want 1 010 7", ACK_A, WE, WDATA);
    end
    REQ_A = 1'b0;
    tick();
    PTR_LD = 1'b1; PTR_VAL = 2'd3;
    tick();
    nTests++;
    if (PTR !== 3'b100) begin
      nFail++;
      $display("FAIL ptr_ld_val3: PTR=%b want 100", PTR);
    end
    PTR_VAL = 2'd0;
    tick();
    nTests++;
    if (PTR !== 3'b001) begin
      nFail++;
      $display("FAIL ptr_ld_val0: PTR=%b want 001", PTR);
    end
    PTR_LD = 1'b0;
  endtask

  task automatic test_mid_write();
    doReset();
    REQ_A = 1'b1; DATA_A = 4'hC;
    tick();
    REQ_A = 1'b0; PTR_LD = 1'b1; PTR_VAL = 2'd2;
    tick();
    nTests++;
    if ({PTR, BUSY} !== {3'b001, 1'b0}) begin
      nFail++;
      $display("FAIL midwrite_ld_ignored: PTR=%b BUSY=%b, want 001 0", PTR, BUSY);
    end
    PTR_LD = 1'b0;
    tick();
    nTests++;
    if (PTR !== 3'b001) begin
      nFail++;
      $display("FAIL midwrite_ld_not_deferred: PTR=%b want 001", PTR);
    end
    REQ_A = 1'b1;
    tick();
    REQ_A = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    nTests++;
    if ({WE, ACK_A, ACK_B, PTR, BUSY} !== {3'b000, 1'b0, 1'b0, 3'b100, 1'b0}) begin
      nFail++;
      $display("FAIL midwrite_reset: WE=%b ACK_A=%b ACK_B=%b PTR=%b BUSY=%b, want 000 0 0 100 0",
               WE, ACK_A, ACK_B, PTR, BUSY);
    end
  endtask

  task automatic test_random();
    doReset();
    mIdx = 2; mBusy = 0; mLastA = 0; mWe = 0; mWdata = 0; mAckA = 0; mAckB = 0;
    for (int c = 0; c < 600; c++) begin
      RST     = ($urandom_range(0, 59) == 0);
      REQ_A   = ($urandom_range(0, 2) != 0);
      REQ_B   = ($urandom_range(0, 2) != 0);
      DATA_A  = 4'($urandom);
      DATA_B  = 4'($urandom);
      HOLD    = ($urandom_range(0, 5) == 0);
      PTR_LD  = ($urandom_range(0, 7) == 0);
      PTR_VAL = 2'($urandom);
      modelStep();
      tick();
      nTests++;
      if ({ACK_A, ACK_B, WE, WDATA, PTR, BUSY} !== {mAckA, mAckB, mWe, mWdata, idxHot(mIdx), mBusy}) begin
        nFail++;
        $display("FAIL random_cyc%0d: ACK_A=%b ACK_B=%b WE=%b WDATA=%h PTR=%b BUSY=%b, want %b %b %b %h %b %b",
                 c, ACK_A, ACK_B, WE, WDATA, PTR, BUSY,
                 mAckA, mAckB, mWe, mWdata, idxHot(mIdx), mBusy);
      end
      nTests++;
      if ((ACK_A && ACK_B) || (WE != 3'b000 && !$onehot(WE))) begin
        nFail++;
        $display("FAIL random_invariant%0d: ACK_A=%b ACK_B=%b WE=%b, want exclusive acks and one-hot WE",
                 c, ACK_A, ACK_B, WE);
      end
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_a_stream();
    test_tie();
    test_hold();
    test_ptr_ld();
    test_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
